// File: rtl/pit_audio_pkg.sv
// Shared constants and helpers for the PIT audio path.
package pit_audio_pkg;

  localparam int          PIT_OUT_W     = 16;
  localparam int          PIT_SHIFT     = 4;
  localparam logic [15:0] PIT_LEVEL     = 16'h3000;
  localparam logic [15:0] PIT_AUX_LEVEL = 16'h1000;
  localparam int          PIT_CHANNELS  = 3;

  // Clamp an unsigned value to the largest number representable in 'width' bits.
  function automatic logic [63:0] sat_to_width(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/pit_audio_sdm.sv
// First-order sigma-delta modulator: dout density tracks din / 2^OUT_W.
module pit_audio_sdm #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] din,
  output logic             dout
);

  logic [OUT_W:0] sd;
  logic [OUT_W:0] sd_next;

  // Carry out of the fractional accumulator is the output bit.
  always_comb begin
    sd_next = {1'b0, sd[OUT_W-1:0]} + {1'b0, din};
  end

  // Accumulator and output bit, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd   <= '0;
      dout <= 1'b0;
    end else begin
      sd   <= sd_next;
      dout <= sd_next[OUT_W];
    end
  end

endmodule

// File: rtl/pit_sound_mixer.sv
// Mixes the three PIT outputs plus an aux bit, low-pass filters the mix
// with a one-pole IIR, and drives a sigma-delta DAC bit.
module pit_sound_mixer
  import pit_audio_pkg::*;
#(
  parameter int               OUT_W     = PIT_OUT_W,
  parameter int               SHIFT     = PIT_SHIFT,
  parameter logic [OUT_W-1:0] LEVEL     = OUT_W'(PIT_LEVEL),
  parameter logic [OUT_W-1:0] AUX_LEVEL = OUT_W'(PIT_AUX_LEVEL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tce,
  input  logic [2:0]       pit_out,
  input  logic [2:0]       ch_en,
  input  logic             aux,
  output logic [OUT_W-1:0] audio,
  output logic             audio_valid,
  output logic             dac_bit
);

  // Two guard bits hold the worst-case sum of three channels plus aux.
  localparam int SUM_W = OUT_W + 2;
  // Fractional bits below the sample keep the IIR from stalling on truncation.
  localparam int ACC_W = OUT_W + SHIFT;

  logic [SUM_W-1:0] chan_term [PIT_CHANNELS];
  logic [SUM_W-1:0] raw_sum;
  logic [OUT_W-1:0] mix_sat;
  logic [OUT_W-1:0] mix;
  logic             mix_ce;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  // Each enabled, high channel contributes one LEVEL.
  genvar gi;
  generate
    for (gi = 0; gi < PIT_CHANNELS; gi++) begin : g_chan
      assign chan_term[gi] = (pit_out[gi] && ch_en[gi]) ? SUM_W'(LEVEL) : '0;
    end
  endgenerate

  // Sum the channel terms and aux, then clamp to the sample range.
  always_comb begin
    raw_sum = aux ? SUM_W'(AUX_LEVEL) : '0;
    for (int i = 0; i < PIT_CHANNELS; i++) begin
      raw_sum = raw_sum + chan_term[i];
    end
    mix_sat = OUT_W'(sat_to_width(64'(raw_sum), OUT_W));
  end

  // Stage 1: capture the mix only on timer strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix    <= '0;
      mix_ce <= 1'b0;
    end else begin
      mix_ce <= tce;
      if (tce) begin
        mix <= mix_sat;
      end
    end
  end

  // acc settles at mix << SHIFT, so the intermediate wrap is harmless.
  always_comb begin
    acc_next = acc + ACC_W'(mix) - (acc >> SHIFT);
  end

  // Stage 2: IIR update and output sample, one per captured mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      audio       <= '0;
      audio_valid <= 1'b0;
    end else begin
      audio_valid <= mix_ce;
      if (mix_ce) begin
        acc   <= acc_next;
        audio <= acc_next[ACC_W-1:SHIFT];
      end
    end
  end

  pit_audio_sdm #(
    .OUT_W(OUT_W)
  ) u_sdm (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (audio),
    .dout (dac_bit)
  );

endmodule

// File: tb/tb_pit_sound_mixer.sv
// Self-checking bench: a default-parameter mixer and a saturating variant
// share the same stimulus and are compared against an arithmetic model.
module tb_pit_sound_mixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tce = 1'b0;
  logic [2:0]  pit_out = 3'b000;
  logic [2:0]  ch_en = 3'b000;
  logic        aux = 1'b0;
  logic [15:0] audio_o [2];
  logic        av_o [2];
  logic        dac_o [2];

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance (0 = defaults, 1 = saturating levels).
  int unsigned lvl [2]     = '{32'h3000, 32'h6000};
  int unsigned aux_lvl [2] = '{32'h1000, 32'h4000};
  int unsigned m_acc [2];
  int unsigned m_audio [2];
  int unsigned m_sd [2];
  int unsigned m_dac [2];
  logic        m_valid;
  int unsigned q_due [$];
  int unsigned q_v0 [$];
  int unsigned q_v1 [$];
  int unsigned cyc = 0;
  bit          chk_each = 1'b1;

  always #5 clk = ~clk;

  pit_sound_mixer dut (
    .clk(clk), .rst_n(rst_n), .tce(tce), .pit_out(pit_out), .ch_en(ch_en), .aux(aux),
    .audio(audio_o[0]), .audio_valid(av_o[0]), .dac_bit(dac_o[0])
  );

  pit_sound_mixer #(
    .LEVEL(16'h6000), .AUX_LEVEL(16'h4000)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .tce(tce), .pit_out(pit_out), .ch_en(ch_en), .aux(aux),
    .audio(audio_o[1]), .audio_valid(av_o[1]), .dac_bit(dac_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_mix(input int k);
    int unsigned s;
    s = lvl[k] * $countones(pit_out & ch_en) + (aux ? aux_lvl[k] : 0);
    return (s > 32'hFFFF) ? 32'hFFFF : s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_audio[k] = 0; m_sd[k] = 0; m_dac[k] = 0;
    end
    m_valid = 1'b0;
    q_due.delete(); q_v0.delete(); q_v1.delete();
  endtask

  // One clock: apply tce, advance the model, compare all outputs.
  task automatic tick(input logic t);
    int unsigned s;
    tce = t;
    @(posedge clk);
    #1;
    cyc++;
    m_valid = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        s = m_sd[k] + m_audio[k];
        m_dac[k] = (s >> 16) & 1;
        m_sd[k] = s & 32'hFFFF;
      end
      if (q_due.size() != 0 && q_due[0] == cyc) begin
        void'(q_due.pop_front());
        m_audio[0] = q_v0.pop_front();
        m_audio[1] = q_v1.pop_front();
        m_valid = 1'b1;
      end
      if (t) begin
        for (int k = 0; k < 2; k++) m_acc[k] = m_acc[k] + model_mix(k) - m_acc[k] / 16;
        q_v0.push_back(m_acc[0] / 16);
        q_v1.push_back(m_acc[1] / 16);
        q_due.push_back(cyc + 1);
      end
    end
    if (chk_each) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("valid[%0d]@%0d", k, cyc), {31'd0, av_o[k]}, {31'd0, m_valid});
        check($sformatf("audio[%0d]@%0d", k, cyc), {16'd0, audio_o[k]}, m_audio[k]);
        check($sformatf("dac[%0d]@%0d", k, cyc), {31'd0, dac_o[k]}, m_dac[k]);
      end
    end
  endtask

  initial begin
    int          ones [2];
    logic [15:0] prev_dec;
    int          pulses;
    int          first_idx;
    int          waited;

    model_reset();

    // Reset held with strobes toggling and every input high.
    pit_out = 3'b111; ch_en = 3'b111; aux = 1'b1;
    for (int i = 0; i < 8; i++) tick(i[0]);
    check("reset_audio", {16'd0, audio_o[0]}, 32'd0);

    // Release, one strobe with all inputs low.
    rst_n = 1'b1;
    pit_out = 3'b000; ch_en = 3'b000; aux = 1'b0;
    tick(1'b1); tick(1'b0);
    check("zero_valid", {31'd0, av_o[0]}, 32'd1);
    check("zero_audio", {16'd0, audio_o[0]}, 32'd0);
    tick(1'b0);

    // Step response; the saturating instance sees 0x16000 clamped to 0xFFFF.
    pit_out = 3'b111; ch_en = 3'b111; aux = 1'b1;
    tick(1'b1); tick(1'b0);
    check("step_first", {16'd0, audio_o[0]}, 32'h0A00);
    check("sat_first", {16'd0, audio_o[1]}, 32'h0FFF);
    for (int i = 0; i < 199; i++) tick(1'b1);
    tick(1'b0); tick(1'b0);
    check("step_settle", {31'd0, (audio_o[0] >= 16'h9FFF && audio_o[0] <= 16'hA001)}, 32'd1);
    check("sat_settle", {31'd0, (audio_o[1] >= 16'hFFFE)}, 32'd1);

    // Enable masking; inputs wiggle between strobes and must be ignored.
    for (int i = 0; i < 300; i++) begin
      pit_out = 3'($urandom); ch_en = 3'($urandom); aux = 1'($urandom);
      tick(1'b0);
      pit_out = 3'b111; ch_en = 3'b010; aux = 1'b0;
      tick(1'b1);
    end
    tick(1'b0); tick(1'b0);
    check("mask_settle", {16'd0, audio_o[0]}, 32'h3000);

    // All channels disabled: monotonic decay without wrap.
    ch_en = 3'b000;
    prev_dec = audio_o[0];
    for (int i = 0; i < 150; i++) begin
      tick(1'b1);
      if (av_o[0]) begin
        check("decay_mono", {31'd0, (audio_o[0] <= prev_dec)}, 32'd1);
        prev_dec = audio_o[0];
      end
      tick(1'b0);
    end
    check("decay_low", {31'd0, (audio_o[0] < 16'h0010)}, 32'd1);

    // Random inputs and random strobes.
    for (int i = 0; i < 300; i++) begin
      pit_out = 3'($urandom); ch_en = 3'($urandom); aux = 1'($urandom);
      tick(1'($urandom_range(0, 1)));
    end
    tick(1'b0); tick(1'b0); tick(1'b0);

    // Ten back-to-back strobes give ten pulses, the first one edge later.
    pulses = 0; first_idx = -1;
    for (int i = 0; i < 15; i++) begin
      tick(i < 10);
      if (av_o[0]) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check("b2b_pulses", pulses, 32'd10);
    check("b2b_first", first_idx, 32'd1);

    // Settle at 0x4000 and count DAC ones over a full 2^16 window.
    pit_out = 3'b001; ch_en = 3'b001; aux = 1'b1;
    for (int i = 0; i < 300; i++) tick(1'b1);
    tick(1'b0); tick(1'b0); tick(1'b0);
    check("dens_level", {16'd0, audio_o[0]}, 32'h4000);
    ones[0] = 0; ones[1] = 0;
    chk_each = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      tick(1'b0);
      ones[0] += int'(dac_o[0]);
      ones[1] += int'(dac_o[1]);
    end
    chk_each = 1'b1;
    check("dens_ones0", ones[0], 32'd16384);
    check("dens_ones1", ones[1], m_audio[1]);

    // Asynchronous reset mid-window while dac_bit is high.
    waited = 0;
    tick(1'b0);
    while (dac_o[0] !== 1'b1 && waited < 8) begin
      tick(1'b0);
      waited++;
    end
    check("rst_dac_was_high", {31'd0, dac_o[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dac", {31'd0, dac_o[0]}, 32'd0);
    check("async_audio", {16'd0, audio_o[0]}, 32'd0);
    check("async_valid", {31'd0, av_o[0]}, 32'd0);
    model_reset();
    tick(1'b1);
    rst_n = 1'b1;
    tick(1'b1); tick(1'b0); tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pit_sound_mixer.md
# pit_sound_mixer

Mixes the three timer outputs of the `pit8253` and one auxiliary beeper/tape bit into a filtered unsigned PCM sample stream and a 1-bit sigma-delta DAC output. It sits directly downstream of `pit8253`: it consumes `out[2:0]` and is strobed by the same `tce` that clocks the timer. It feeds the board audio path, either the DAC pin or the HDMI/I2S sample interface.

## Interface
Parameters:
- `OUT_W`, 16: sample width.
- `SHIFT`, 4: IIR low-pass coefficient 2^-SHIFT. Legal range 1..8.
- `LEVEL`, 16'h3000: per-timer-channel contribution when that channel output is high.
- `AUX_LEVEL`, 16'h1000: contribution of `aux` when high.

Ports:
- `clk` in 1: system clock, the same clock that drives `pit8253`.
- `rst_n` in 1: asynchronous, active-low reset.
- `tce` in 1: sample strobe, the timer clock enable, one `clk` wide.
- `pit_out` in 3: timer outputs `out[2:0]` from `pit8253`.
- `ch_en` in 3: per-channel mix enable.
- `aux` in 1: beeper/tape bit, already in the `clk` domain.
- `audio` out OUT_W: filtered unsigned sample; 0 = silence floor.
- `audio_valid` out 1: one-cycle pulse when `audio` updates.
- `dac_bit` out 1: first-order sigma-delta output.

## Operation
- **Stage 1 (mix).** Registered on a `clk` edge where `tce`=1.
  - `mix = LEVEL*popcount(pit_out & ch_en) + (aux ? AUX_LEVEL : 0)`.
  - The sum is computed in OUT_W+2 bits and saturated to 2^OUT_W-1.
  - `mix_ce` is set for one cycle.
- **Stage 2 (IIR).** On `mix_ce`:
  - `acc <= acc + mix - (acc >> SHIFT)`. `acc` is OUT_W+SHIFT bits and unsigned.
  - Cannot overflow, because `acc` ≤ `mix_max << SHIFT`.
  - `audio <= acc_next >> SHIFT`.
  - `audio_valid` pulses.
- **Steady state.** Constant `mix` M gives `audio` → M. A step from 0 gives `audio` = M>>SHIFT after the first update.
- **Sigma-delta.** Runs every `clk`, independent of `tce`.
  - `sd <= {1'b0, sd[OUT_W-1:0]} + audio`. `sd` is OUT_W+1 bits.
  - `dac_bit <= sd_next[OUT_W]`.
  - Over 2^OUT_W clocks, the density of `dac_bit` equals `audio`/2^OUT_W.
- **Sampling of inputs.** `ch_en`, `pit_out` and `aux` are sampled only on `tce` cycles. Changes between strobes have no effect.
- There is no state machine beyond the two-stage valid pipeline. Both stages are fully pipelined, so `tce` asserted on every cycle is legal.

## Timing
- **Reset.** All of `mix`, `mix_ce`, `acc`, `audio`, `audio_valid`, `sd` and `dac_bit` are 0 immediately on `rst_n`=0 (asynchronous). Reset asserted mid-pipeline discards the in-flight sample.
- **Latency.** `tce` at edge n leads to `mix` valid after edge n, and `audio`/`audio_valid` after edge n+1. This is 2 cycles from input sample to output.
- **`dac_bit` latency.** `dac_bit` reflects the new `audio` from edge n+2 onward.
- **Back-to-back `tce`.** Each strobe produces exactly one `audio_valid` pulse, 2 cycles later. No strobe is dropped or merged.
- **`ch_en` changing on the same edge as `tce`.** The value present at that edge is used.
- **`tce` held low.** `audio` holds its value and `dac_bit` keeps modulating it.

## Structure
- Package `pit_audio_pkg` holds:
  - default `LEVEL`, `AUX_LEVEL` and `SHIFT` constants;
  - the saturate-to-width function.
- Sub-module `pit_audio_sdm`: parameter `OUT_W`, ports `clk`, `rst_n`, `din[OUT_W-1:0]`, `dout`. It contains the sigma-delta accumulator only and is reused by other audio sources on the board.
- The mix and IIR stages stay in `pit_sound_mixer`.

## Test plan
All scenarios use the default parameters.
- **Reset.** Hold `rst_n`=0 with `tce` toggling and inputs high → `audio`=0, `audio_valid`=0, `dac_bit`=0 throughout. Release, then apply one `tce` with all inputs 0 → `audio_valid` 2 cycles later with `audio`=0.
- **Step response.** `ch_en`=3'b111, `pit_out`=3'b111, `aux`=1 (mix=0xA000), first `tce` after reset → `audio`=0x0A00. After 200 strobes → `audio` within 1 LSB of 0xA000.
- **Enable masking.** `pit_out`=3'b111, `ch_en`=3'b010, `aux`=0 → converges to 0x3000. `ch_en`=3'b000 → decays monotonically toward 0, with no underflow wrap.
- **Saturation.** Parameters `LEVEL`=0x6000, `AUX_LEVEL`=0x4000, all inputs high (raw sum 0x16000) → `mix`=0xFFFF, and `audio` never exceeds 0xFFFF.
- **Back-to-back strobes.** `tce` high for 10 consecutive cycles → exactly 10 `audio_valid` pulses, starting 2 cycles after the first strobe.
- **DAC density.** `audio` settled at 0x4000 → exactly 16384 ones in `dac_bit` over 65536 clocks. Asynchronous reset mid-window → `dac_bit` low within the same cycle.
